// File: rtl/nmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nmi_pkg
// Description : Shared types and helpers for the NMI memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
package nmi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } nmi_state_e;

    localparam logic [3:0] NMI_WSTRB_ALL = 4'hF;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nmi_sram_array.sv
`default_nettype none
// ============================================================================
// Module      : nmi_sram_array
// Description : DEPTH x 32 word RAM, per-byte write enable, synchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module nmi_sram_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [3:0]       i_be,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_byte
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_q;

            always_ff @(posedge clk) begin
                if (i_we && i_be[g]) begin
                    r_mem[i_waddr] <= i_wdata[8*g +: 8];
                end
                if (i_re) begin
                    r_q <= r_mem[i_raddr];
                end
            end

            assign o_rdata[8*g +: 8] = r_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/nmi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : nmi_mem_slave
// Description : NMI bus target with local word RAM, wait states, counters and
//               sticky range/protocol error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module nmi_mem_slave
    import nmi_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    WSTRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA   = 32'hDEADBEEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_mem_valid,
    output logic                   s_mem_ready,
    input  logic                   s_mem_instr,
    input  logic [ADDR_WIDTH-1:0]  s_mem_addr,
    input  logic [DATA_WIDTH-1:0]  s_mem_wdata,
    input  logic [WSTRB_WIDTH-1:0] s_mem_wstrb,
    output logic [DATA_WIDTH-1:0]  s_mem_rdata,
    output logic [15:0]            wr_count,
    output logic [15:0]            rd_count,
    output logic [15:0]            if_count,
    output logic                   range_err,
    output logic                   proto_err,
    input  logic                   err_clr
);

    localparam int                    c_idx_w     = clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_span      = ADDR_WIDTH'(4 * DEPTH);
    localparam logic [3:0]            c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    nmi_state_e             r_state;
    nmi_state_e             w_next;
    logic [3:0]             r_wait_cnt;
    logic                   r_addr_ok;
    logic [c_idx_w-1:0]     r_idx;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [WSTRB_WIDTH-1:0] r_wstrb;
    logic                   r_instr;

    logic                   w_capture;
    logic                   w_to_resp;
    logic                   w_abort;
    logic [ADDR_WIDTH-1:0]  w_live_off;
    logic                   w_live_ok;
    logic [c_idx_w-1:0]     w_live_idx;
    logic [c_idx_w-1:0]     w_rd_idx;
    logic                   w_done;
    logic                   w_is_write;
    logic                   w_ram_we;
    logic [31:0]            w_ram_q;
    logic                   w_range_set;
    logic                   w_proto_set;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the compare.
    assign w_live_off = s_mem_addr - BASE_ADDR;
    assign w_live_ok  = (w_live_off < c_span);
    assign w_live_idx = w_live_off[c_idx_w+1:2];

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_to_resp = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            IDLE: begin
                if (s_mem_valid) begin
                    w_capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_next    = RESP;
                        w_to_resp = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!s_mem_valid) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else if (r_wait_cnt == 4'd0) begin
                    w_next    = RESP;
                    w_to_resp = 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_addr_ok  <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_instr    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_wait_cnt <= c_wait_load;
                r_addr_ok  <= w_live_ok;
                r_idx      <= w_live_idx;
                r_wdata    <= s_mem_wdata;
                r_wstrb    <= s_mem_wstrb;
                r_instr    <= s_mem_instr;
            end else if (r_state == WAIT && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    // With zero wait states the read is launched from the live address.
    assign w_rd_idx   = (r_state == IDLE) ? w_live_idx : r_idx;
    assign w_done     = (r_state == RESP);
    assign w_is_write = (r_wstrb != '0);
    assign w_ram_we   = w_done && r_addr_ok && w_is_write;

    nmi_sram_array #(
        .DEPTH (DEPTH),
        .IDX_W (c_idx_w)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_be    (r_wstrb & NMI_WSTRB_ALL),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_re    (w_to_resp),
        .i_raddr (w_rd_idx),
        .o_rdata (w_ram_q)
    );

    assign s_mem_ready = w_done;

    always_comb begin
        s_mem_rdata = '0;
        if (w_done && !w_is_write) begin
            s_mem_rdata = r_addr_ok ? w_ram_q : ERR_RDATA;
        end
    end

    assign w_range_set = w_done && !r_addr_ok;
    assign w_proto_set = w_abort || (w_done && !s_mem_valid);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_count  <= 16'd0;
            rd_count  <= 16'd0;
            if_count  <= 16'd0;
            range_err <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (w_done) begin
                if (w_is_write) begin
                    wr_count <= wr_count + 16'd1;
                end else begin
                    rd_count <= rd_count + 16'd1;
                    if (r_instr) begin
                        if_count <= if_count + 16'd1;
                    end
                end
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            if (w_range_set) begin
                range_err <= 1'b1;
            end else if (err_clr) begin
                range_err <= 1'b0;
            end
            if (w_proto_set) begin
                proto_err <= 1'b1;
            end else if (err_clr) begin
                proto_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nmi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_nmi_mem_slave
// Description : Self-checking bench for nmi_mem_slave against a word-array model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nmi_mem_slave;

    localparam int          c_wait  = 2;
    localparam int          c_depth = 256;
    localparam logic [31:0] c_err   = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        valid = 1'b0, instr = 1'b0, err_clr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        ready, range_err, proto_err;
    logic [31:0] rdata;
    logic [15:0] wr_count, rd_count, if_count;

    logic        valid_z = 1'b0;
    logic [31:0] addr_z = '0, wdata_z = '0;
    logic [3:0]  wstrb_z = '0;
    logic        ready_z, range_err_z, proto_err_z;
    logic [31:0] rdata_z;
    logic [15:0] wr_count_z, rd_count_z, if_count_z;

    nmi_mem_slave #(.WAIT_CYCLES(c_wait)) dut (
        .clk(clk), .rstn(rstn), .s_mem_valid(valid), .s_mem_ready(ready),
        .s_mem_instr(instr), .s_mem_addr(addr), .s_mem_wdata(wdata),
        .s_mem_wstrb(wstrb), .s_mem_rdata(rdata), .wr_count(wr_count),
        .rd_count(rd_count), .if_count(if_count), .range_err(range_err),
        .proto_err(proto_err), .err_clr(err_clr)
    );

    nmi_mem_slave #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn), .s_mem_valid(valid_z), .s_mem_ready(ready_z),
        .s_mem_instr(1'b0), .s_mem_addr(addr_z), .s_mem_wdata(wdata_z),
        .s_mem_wstrb(wstrb_z), .s_mem_rdata(rdata_z), .wr_count(wr_count_z),
        .rd_count(rd_count_z), .if_count(if_count_z), .range_err(range_err_z),
        .proto_err(proto_err_z), .err_clr(1'b0)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mdl_mem [c_depth];
    logic [15:0] mdl_wr = '0, mdl_rd = '0, mdl_if = '0;
    logic        mdl_range = 1'b0, mdl_proto = 1'b0;

    task automatic check_status(input string tag);
        n_vec++;
        if ({wr_count, rd_count, if_count} !== {mdl_wr, mdl_rd, mdl_if}) begin
            n_err++;
            $display("FAIL %s counters: got wr=%0d rd=%0d if=%0d expected wr=%0d rd=%0d if=%0d",
                     tag, wr_count, rd_count, if_count, mdl_wr, mdl_rd, mdl_if);
        end
        n_vec++;
        if ({range_err, proto_err} !== {mdl_range, mdl_proto}) begin
            n_err++;
            $display("FAIL %s flags: got range=%b proto=%b expected range=%b proto=%b",
                     tag, range_err, proto_err, mdl_range, mdl_proto);
        end
    endtask

    // One complete handshake on the wait-state DUT, checked against the model.
    task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic ins, input string tag, output logic [31:0] got);
        logic [31:0] exp_rd;
        bit          in_rng;
        int          idx;
        int          lat;
        bit          spurious;
        in_rng   = (a < 32'(4 * c_depth));
        idx      = int'(a[9:2]);
        exp_rd   = (ws != 4'd0) ? 32'd0 : (in_rng ? mdl_mem[idx] : c_err);
        got      = 'x;
        lat      = 0;
        spurious = 0;
        @(negedge clk);
        valid = 1'b1; addr = a; wdata = wd; wstrb = ws; instr = ins;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin
                lat = c;
                got = rdata;
            end else if (rdata !== 32'd0) begin
                spurious = 1;
            end
        end
        @(posedge clk); #1;
        valid = 1'b0; addr = $urandom; wdata = $urandom; wstrb = 4'($urandom); instr = 1'b0;
        n_vec++;
        if (lat != c_wait + 1) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles expected %0d", tag, lat, c_wait + 1);
        end
        n_vec++;
        if (got !== exp_rd) begin
            n_err++;
            $display("FAIL %s rdata: got %h expected %h", tag, got, exp_rd);
        end
        n_vec++;
        if (spurious || ready !== 1'b0 || rdata !== 32'd0) begin
            n_err++;
            $display("FAIL %s idle outputs: got ready=%b rdata=%h early_rdata=%0d expected ready=0 rdata=0",
                     tag, ready, rdata, spurious);
        end
        if (ws != 4'd0) begin
            mdl_wr++;
            if (in_rng) begin
                for (int b = 0; b < 4; b++) begin
                    if (ws[b]) mdl_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end else begin
            mdl_rd++;
            if (ins) mdl_if++;
        end
        if (!in_rng) mdl_range = 1'b1;
        check_status(tag);
    endtask

    task automatic pulse_clr();
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        mdl_range = 1'b0;
        mdl_proto = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_vec++;
        if (ready !== 1'b0 || rdata !== 32'd0 || ready_z !== 1'b0 || rdata_z !== 32'd0) begin
            n_err++;
            $display("FAIL reset outputs: got ready=%b rdata=%h ready0=%b rdata0=%h expected 0",
                     ready, rdata, ready_z, rdata_z);
        end
        n_vec++;
        if ({wr_count_z, rd_count_z, if_count_z, range_err_z, proto_err_z} !== 50'd0) begin
            n_err++;
            $display("FAIL reset dut0 status: got wr=%0d rd=%0d if=%0d expected all 0",
                     wr_count_z, rd_count_z, if_count_z);
        end
        check_status("reset");
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] got;
        xfer(32'h10, 32'h1000_03E8, 4'hF, 1'b0, "write_full", got);
        xfer(32'h10, 32'h0, 4'h0, 1'b0, "read", got);
        xfer(32'h10, 32'h0, 4'h0, 1'b1, "fetch", got);
    endtask

    task automatic test_strobe();
        logic [31:0] got;
        xfer(32'h10, 32'hAABB_CCDD, 4'b0010, 1'b0, "write_byte1", got);
        xfer(32'h10, 32'h0, 4'h0, 1'b0, "read_merged", got);
        n_vec++;
        if (got !== 32'h1000_CCE8) begin
            n_err++;
            $display("FAIL strobe_merge: got %h expected 1000cce8", got);
        end
    endtask

    task automatic test_range();
        logic [31:0] got;
        xfer(32'h400, 32'h0, 4'h0, 1'b0, "range_read", got);
        xfer(32'h404, 32'h1234_5678, 4'hF, 1'b0, "range_write", got);
        pulse_clr();
        check_status("range_clr");
    endtask

    task automatic test_proto();
        logic [31:0] got;
        bit          seen;
        seen = 0;
        @(negedge clk);
        valid = 1'b1; addr = 32'h10; wdata = 32'h5555_5555; wstrb = 4'hF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ready !== 1'b0) seen = 1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL proto_abort: got ready=1 after drop expected no ready");
        end
        mdl_proto = 1'b1;
        check_status("proto_abort");
        pulse_clr();
        check_status("proto_clr");
        xfer(32'h10, 32'h0, 4'h0, 1'b0, "proto_ram_intact", got);
    endtask

    task automatic test_back_to_back();
        bit exp_rdy;
        @(negedge clk);
        valid_z = 1'b1; addr_z = 32'h20; wdata_z = $urandom; wstrb_z = 4'hF;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            exp_rdy = (c % 2) == 1;
            n_vec++;
            if (ready_z !== exp_rdy) begin
                n_err++;
                $display("FAIL b2b cycle %0d: got ready=%b expected %b", c, ready_z, exp_rdy);
            end
        end
        valid_z = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (wr_count_z !== 16'd6 || proto_err_z !== 1'b0 || rd_count_z !== 16'd0) begin
            n_err++;
            $display("FAIL b2b status: got wr=%0d rd=%0d proto=%b expected wr=6 rd=0 proto=0",
                     wr_count_z, rd_count_z, proto_err_z);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, a;
        logic [3:0]  ws;
        for (int i = 0; i < c_depth; i++) begin
            xfer(32'(i * 4), $urandom, 4'hF, 1'b0, "fill", got);
        end
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 4 * c_depth - 1));
            else                          a = 32'h400 + ($urandom % 32'h0010_0000);
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            xfer(a, $urandom, ws, (ws == 4'h0) ? 1'($urandom) : 1'b0, "random", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        @(negedge clk);
        valid = 1'b1; addr = 32'h14; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        @(posedge clk); #1;
        @(negedge clk); rstn = 1'b0;
        #1;
        mdl_wr = '0; mdl_rd = '0; mdl_if = '0; mdl_range = 1'b0; mdl_proto = 1'b0;
        n_vec++;
        if (ready !== 1'b0 || wr_count_z !== 16'd0) begin
            n_err++;
            $display("FAIL midreset outputs: got ready=%b wr0=%0d expected ready=0 wr0=0",
                     ready, wr_count_z);
        end
        check_status("midreset");
        valid = 1'b0;
        @(negedge clk); rstn = 1'b1;
        for (int c = 0; c < 4; c++) @(posedge clk);
        #1;
        check_status("midreset_after");
        xfer(32'h14, 32'h0, 4'h0, 1'b0, "midreset_ram", got);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_range();
        test_proto();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
